// File: rtl/calc2_pkg.sv
// Shared types for the calc2 request port: command/response encodings,
// the buffered request record and a small command classifier.
package calc2_pkg;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;

  // cmd is kept as raw bits so invalid encodings survive to the executor
  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  tag;
    logic [31:0] op1;
    logic [31:0] op2;
  } req_t;

  function automatic logic is_shift(input logic [3:0] cmd);
    return (cmd == CMD_SHL) || (cmd == CMD_SHR);
  endfunction

endpackage

// File: rtl/calc2_port_responder_if.sv
// calc2 request/response port: the initiator drives req_*, the responder
// drives the response and drop indication.
interface calc2_port_responder_if;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic [1:0]  req_tag_in;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic [1:0]  out_tag;
  logic        drop_err;

  modport master (
    output req_cmd_in, req_data_in, req_tag_in,
    input  out_resp, out_data, out_tag, drop_err
  );

  modport slave (
    input  req_cmd_in, req_data_in, req_tag_in,
    output out_resp, out_data, out_tag, drop_err
  );
endinterface

// File: rtl/calc2_req_fifo.sv
// In-order request buffer; a push into a full FIFO succeeds when a pop
// happens in the same cycle.
module calc2_req_fifo
  import calc2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  req_t data_i,
  output req_t data_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);

  req_t          mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push_s, do_pop_s;

  assign empty_o   = (cnt_q == (AW+1)'(0));
  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);
  assign data_o    = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= AW'(0);
      rd_q  <= AW'(0);
      cnt_q <= (AW+1)'(0);
    end else begin
      if (do_push_s) wr_q <= wr_q + AW'(1);
      if (do_pop_s)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
    end
  end
endmodule

// File: rtl/calc2_port_responder.sv
// calc2 responder: two-cycle request capture, in-order buffering, and an
// executor with a one-bit-per-cycle shifter producing one response per request.
module calc2_port_responder
  import calc2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic                   c_clk,
  input logic                   reset,
  calc2_port_responder_if.slave bus
);
  localparam logic [0:0] CAP_OP1 = 1'b0;
  localparam logic [0:0] CAP_OP2 = 1'b1;
  localparam logic [1:0] EX_IDLE = 2'd0;
  localparam logic [1:0] EX_EXEC = 2'd1;
  localparam logic [1:0] EX_RESP = 2'd2;

  logic [0:0]  cap_state_q, cap_state_d;
  logic [3:0]  cap_cmd_q, cap_cmd_d;
  logic [1:0]  cap_tag_q, cap_tag_d;
  logic [31:0] cap_op1_q, cap_op1_d;
  logic [1:0]  ex_state_q, ex_state_d;
  logic [3:0]  ex_cmd_q, ex_cmd_d;
  logic [1:0]  ex_tag_q, ex_tag_d;
  logic [31:0] acc_q, acc_d, opb_q, opb_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  resp_q, resp_d, tag_q, tag_d;
  logic [31:0] data_q, data_d;
  logic        drop_q, drop_d;
  logic        push_s, pop_s, fifo_full_s, fifo_empty_s, done_s;
  req_t        push_req_s, head_s;
  logic [32:0] sum_s;
  logic [31:0] step_s, res_data_s;
  logic [1:0]  res_resp_s;

  always_comb begin
    cap_state_d = cap_state_q;
    cap_cmd_d   = cap_cmd_q;
    cap_tag_d   = cap_tag_q;
    cap_op1_d   = cap_op1_q;
    if (cap_state_q == CAP_OP1) begin
      if (bus.req_cmd_in != 4'd0) begin
        cap_cmd_d   = bus.req_cmd_in;
        cap_tag_d   = bus.req_tag_in;
        cap_op1_d   = bus.req_data_in;
        cap_state_d = CAP_OP2;
      end else begin
        cap_state_d = CAP_OP1;
      end
    end else begin
      cap_state_d = CAP_OP1;
    end
  end

  assign push_s     = (cap_state_q == CAP_OP2);
  assign push_req_s = '{cmd: cap_cmd_q, tag: cap_tag_q, op1: cap_op1_q, op2: bus.req_data_in};
  assign pop_s      = !fifo_empty_s && ((ex_state_q == EX_IDLE) || (ex_state_q == EX_RESP));

  calc2_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (c_clk),
    .rst     (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (push_req_s),
    .data_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Result of the operation currently in EXEC; shifts finish on a count of 0 or 1
  always_comb begin
    sum_s      = {1'b0, acc_q} + {1'b0, opb_q};
    step_s     = (ex_cmd_q == CMD_SHL) ? {acc_q[30:0], 1'b0} : {1'b0, acc_q[31:1]};
    done_s     = !is_shift(ex_cmd_q) || (cnt_q <= 5'd1);
    res_resp_s = RESP_ERR;
    res_data_s = 32'd0;
    case (ex_cmd_q)
      CMD_ADD: begin
        if (!sum_s[32]) begin
          res_resp_s = RESP_OK;
          res_data_s = sum_s[31:0];
        end else begin
          res_resp_s = RESP_ERR;
        end
      end
      CMD_SUB: begin
        if (opb_q <= acc_q) begin
          res_resp_s = RESP_OK;
          res_data_s = acc_q - opb_q;
        end else begin
          res_resp_s = RESP_ERR;
        end
      end
      CMD_SHL, CMD_SHR: begin
        res_resp_s = RESP_OK;
        res_data_s = (cnt_q == 5'd0) ? acc_q : step_s;
      end
      default: res_resp_s = RESP_ERR;
    endcase
  end

  always_comb begin
    ex_state_d = ex_state_q;
    ex_cmd_d   = ex_cmd_q;
    ex_tag_d   = ex_tag_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    cnt_d      = cnt_q;
    resp_d     = resp_q;
    data_d     = data_q;
    tag_d      = tag_q;
    drop_d     = push_s && fifo_full_s && !pop_s;
    case (ex_state_q)
      EX_IDLE, EX_RESP: begin
        resp_d = RESP_NONE;
        data_d = 32'd0;
        tag_d  = 2'd0;
        if (pop_s) begin
          ex_cmd_d   = head_s.cmd;
          ex_tag_d   = head_s.tag;
          acc_d      = head_s.op1;
          opb_d      = head_s.op2;
          cnt_d      = head_s.op2[4:0];
          ex_state_d = EX_EXEC;
        end else begin
          ex_state_d = EX_IDLE;
        end
      end
      EX_EXEC: begin
        if (done_s) begin
          resp_d     = res_resp_s;
          data_d     = res_data_s;
          tag_d      = ex_tag_q;
          ex_state_d = EX_RESP;
        end else begin
          acc_d = step_s;
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: begin
        resp_d     = RESP_NONE;
        data_d     = 32'd0;
        tag_d      = 2'd0;
        ex_state_d = EX_IDLE;
      end
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      cap_state_q <= CAP_OP1;
      cap_cmd_q   <= 4'd0;
      cap_tag_q   <= 2'd0;
      cap_op1_q   <= 32'd0;
      ex_state_q  <= EX_IDLE;
      ex_cmd_q    <= 4'd0;
      ex_tag_q    <= 2'd0;
      acc_q       <= 32'd0;
      opb_q       <= 32'd0;
      cnt_q       <= 5'd0;
      resp_q      <= 2'd0;
      data_q      <= 32'd0;
      tag_q       <= 2'd0;
      drop_q      <= 1'b0;
    end else begin
      cap_state_q <= cap_state_d;
      cap_cmd_q   <= cap_cmd_d;
      cap_tag_q   <= cap_tag_d;
      cap_op1_q   <= cap_op1_d;
      ex_state_q  <= ex_state_d;
      ex_cmd_q    <= ex_cmd_d;
      ex_tag_q    <= ex_tag_d;
      acc_q       <= acc_d;
      opb_q       <= opb_d;
      cnt_q       <= cnt_d;
      resp_q      <= resp_d;
      data_q      <= data_d;
      tag_q       <= tag_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.out_resp = resp_q;
  assign bus.out_data = data_q;
  assign bus.out_tag  = tag_q;
  assign bus.drop_err = drop_q;
endmodule

// File: tb/tb_calc2_port_responder.sv
// Bench for calc2_port_responder: a cycle-level reference model predicts when
// each response and drop pulse appears; table vectors and corner sequences.
module tb_calc2_port_responder;
  import calc2_pkg::*;

  localparam int DEPTH = 4;

  logic c_clk = 1'b0;
  logic reset;

  calc2_port_responder_if bus();

  calc2_port_responder #(.FIFO_DEPTH(DEPTH)) dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 c_clk = ~c_clk;

  typedef struct {
    int          edge_r;
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
  } exp_t;

  typedef struct {
    logic [3:0]  cmd;
    logic [1:0]  tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  er;
    logic [31:0] ed;
  } vec_t;

  exp_t exp_q[$];
  int   pop_edges[$];
  int   drop_q[$];
  int   edge_n    = 0;
  int   last_r    = -1000;
  int   n_cmp     = 0;
  int   n_bad     = 0;
  int   obs_drops = 0;
  logic [1:0]  seen_resp;
  logic [31:0] seen_data;
  logic [1:0]  seen_tag;
  vec_t vecs[9];

  function automatic void ref_calc(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                   output logic [1:0] r, output logic [31:0] d);
    logic [32:0] s;
    r = 2'd1;
    d = 32'd0;
    if (cmd == 4'd1) begin
      s = {1'b0, a} + {1'b0, b};
      if (s[32]) r = 2'd2;
      else d = s[31:0];
    end else if (cmd == 4'd2) begin
      if (b > a) r = 2'd2;
      else d = a - b;
    end else if (cmd == 4'd5) begin
      d = a << b[4:0];
    end else if (cmd == 4'd6) begin
      d = a >> b[4:0];
    end else begin
      r = 2'd2;
    end
  endfunction

  // Request completes at edge e: decide drop vs. accept and when it answers
  function automatic void model_push(input int e, input logic [3:0] cmd, input logic [1:0] tag,
                                     input logic [31:0] a, input logic [31:0] b);
    int occ, p, lat;
    logic [1:0] r;
    logic [31:0] d;
    occ = 0;
    while (pop_edges.size() > 0 && pop_edges[0] <= e) void'(pop_edges.pop_front());
    occ = pop_edges.size();
    if (occ >= DEPTH) begin
      drop_q.push_back(e);
    end else begin
      p = (e + 1 > last_r + 1) ? e + 1 : last_r + 1;
      if (cmd == 4'd5 || cmd == 4'd6) lat = (b[4:0] == 5'd0) ? 1 : int'(b[4:0]);
      else lat = 1;
      last_r = p + lat;
      pop_edges.push_back(p);
      ref_calc(cmd, a, b, r, d);
      exp_q.push_back('{last_r, r, d, tag});
    end
  endfunction

  task automatic check_cycle();
    exp_t x;
    logic [1:0]  er = 2'd0;
    logic [31:0] ed = 32'd0;
    logic [1:0]  et = 2'd0;
    logic        edrop = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].edge_r == edge_n) begin
      x  = exp_q.pop_front();
      er = x.resp;
      ed = x.data;
      et = x.tag;
    end
    n_cmp++;
    if (bus.out_resp !== er || bus.out_data !== ed || bus.out_tag !== et) begin
      n_bad++;
      $display("FAIL resp_stream edge=%0d got resp=%0d data=%h tag=%0d required resp=%0d data=%h tag=%0d",
               edge_n, bus.out_resp, bus.out_data, bus.out_tag, er, ed, et);
    end
    if (drop_q.size() > 0 && drop_q[0] == edge_n) begin
      void'(drop_q.pop_front());
      edrop = 1'b1;
    end
    n_cmp++;
    if (bus.drop_err !== edrop) begin
      n_bad++;
      $display("FAIL drop_err edge=%0d got %b required %b", edge_n, bus.drop_err, edrop);
    end
    if (bus.drop_err === 1'b1) obs_drops++;
    if (bus.out_resp !== 2'd0) begin
      seen_resp = bus.out_resp;
      seen_data = bus.out_data;
      seen_tag  = bus.out_tag;
    end
  endtask

  task automatic tick();
    logic rst_at_edge;
    rst_at_edge = reset;
    @(posedge c_clk);
    edge_n++;
    #1;
    if (rst_at_edge) begin
      exp_q.delete();
      pop_edges.delete();
      drop_q.delete();
      last_r = -1000;
    end
    check_cycle();
  endtask

  task automatic send(input logic [3:0] cmd, input logic [1:0] tag, input logic [31:0] a,
                      input logic [31:0] b, input logic hold);
    bus.req_cmd_in  = cmd;
    bus.req_tag_in  = tag;
    bus.req_data_in = a;
    tick();
    bus.req_cmd_in  = hold ? 4'd1 : 4'd0;
    bus.req_tag_in  = ~tag;
    bus.req_data_in = b;
    model_push(edge_n + 1, cmd, tag, a, b);
    tick();
    bus.req_cmd_in  = 4'd0;
    bus.req_data_in = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic check_seen(input string name, input logic [1:0] er, input logic [31:0] ed,
                            input logic [1:0] et);
    n_cmp++;
    if (seen_resp !== er || seen_data !== ed || seen_tag !== et) begin
      n_bad++;
      $display("FAIL %s got resp=%0d data=%h tag=%0d required resp=%0d data=%h tag=%0d",
               name, seen_resp, seen_data, seen_tag, er, ed, et);
    end
  endtask

  initial begin
    logic [3:0] cmds[6];
    int d0;
    vecs[0] = '{4'd1, 2'd1, 32'h30, 32'h20, 2'd1, 32'h50};
    vecs[1] = '{4'd2, 2'd2, 32'h10, 32'h20, 2'd2, 32'h0};
    vecs[2] = '{4'd1, 2'd3, 32'hFFFF_FFFF, 32'h1, 2'd2, 32'h0};
    vecs[3] = '{4'd5, 2'd0, 32'h1, 32'd31, 2'd1, 32'h8000_0000};
    vecs[4] = '{4'd6, 2'd1, 32'h8000_0000, 32'd0, 2'd1, 32'h8000_0000};
    vecs[5] = '{4'd3, 2'd2, 32'h1234, 32'h1, 2'd2, 32'h0};
    vecs[6] = '{4'd2, 2'd3, 32'h20, 32'h20, 2'd1, 32'h0};
    vecs[7] = '{4'd6, 2'd3, 32'hF0, 32'd36, 2'd1, 32'hF};
    vecs[8] = '{4'd1, 2'd0, 32'hFFFF_FFFE, 32'h1, 2'd1, 32'hFFFF_FFFF};
    cmds[0] = 4'd1; cmds[1] = 4'd2; cmds[2] = 4'd5;
    cmds[3] = 4'd6; cmds[4] = 4'd3; cmds[5] = 4'hF;

    reset = 1'b1;
    bus.req_cmd_in  = 4'd0;
    bus.req_tag_in  = 2'd0;
    bus.req_data_in = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Table vectors, one at a time from idle
    for (int i = 0; i < 9; i++) begin
      seen_resp = 2'd3;
      seen_data = 32'hDEAD_BEEF;
      seen_tag  = 2'd3;
      send(vecs[i].cmd, vecs[i].tag, vecs[i].a, vecs[i].b, 1'b0);
      drain();
      check_seen($sformatf("vec%0d", i), vecs[i].er, vecs[i].ed, vecs[i].tag);
    end

    // Long shift followed immediately by a zero-count shift: order preserved
    send(4'd5, 2'd0, 32'h1, 32'd31, 1'b0);
    send(4'd6, 2'd1, 32'h8000_0000, 32'd0, 1'b0);
    drain();
    check_seen("shl_then_shr", 2'd1, 32'h8000_0000, 2'd1);

    // cmd held at 1 during the operand-2 cycle must not start a request
    send(4'd1, 2'd2, 32'd5, 32'd6, 1'b1);
    drain();
    for (int i = 0; i < 4; i++) tick();
    check_seen("hold_cmd", 2'd1, 32'd11, 2'd2);

    // Six back-to-back slow shifts into a depth-4 FIFO: exactly one drop
    d0 = obs_drops;
    for (int i = 0; i < 6; i++) send(4'd5, 2'(i % 4), 32'h1, 32'd31, 1'b0);
    drain();
    n_cmp++;
    if (obs_drops - d0 != 1) begin
      n_bad++;
      $display("FAIL drop_count got %0d required 1", obs_drops - d0);
    end

    // Reset mid-shift with two requests queued; nothing stale afterwards
    send(4'd5, 2'd0, 32'h1, 32'd31, 1'b0);
    send(4'd1, 2'd1, 32'd7, 32'd8, 1'b0);
    send(4'd1, 2'd2, 32'd9, 32'd1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    seen_resp = 2'd3;
    send(4'd1, 2'd1, 32'd2, 32'd3, 1'b0);
    drain();
    check_seen("add_after_reset", 2'd1, 32'd5, 2'd1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 80; i++) begin
      logic [3:0]  c;
      logic [31:0] b;
      c = cmds[$urandom_range(0, 5)];
      b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
      send(c, 2'($urandom_range(0, 3)), $urandom, b, 1'($urandom_range(0, 1)));
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
